// File: rtl/eof_error_frame_ctrl.sv
// End-of-frame check and error-frame sequencer for the CAN receive path.
// Drives error flag, delimiter and intermission on TX; flags EOF outcomes.
module eof_error_frame_ctrl #(
  parameter int EOF_LEN   = 7,
  parameter int FLAG_LEN  = 6,
  parameter int DELIM_LEN = 8,
  parameter int IFS_LEN   = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       SP,
  input  logic       RX,
  input  logic       EOF_Flag,
  input  logic       Ext_Error,
  output logic       TX,
  output logic       EOF_Error,
  output logic       Overload,
  output logic       Frame_OK,
  output logic       Busy,
  output logic [2:0] State
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_EOF        = 3'd1,
    S_ERR_FLAG   = 3'd2,
    S_DELIM_WAIT = 3'd3,
    S_DELIM      = 3'd4,
    S_IFS        = 3'd5
  } state_t;

  localparam logic [3:0] EOF_LAST   = 4'(EOF_LEN - 1);
  localparam logic [3:0] FLAG_LAST  = 4'(FLAG_LEN - 1);
  localparam logic [3:0] DELIM_LAST = 4'(DELIM_LEN - 1);
  localparam logic [3:0] IFS_LAST   = 4'(IFS_LEN - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       eof_err_d, ovl_d, ok_d;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      TX        <= 1'b1;
      EOF_Error <= 1'b0;
      Overload  <= 1'b0;
      Frame_OK  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      TX        <= (state_d != S_ERR_FLAG);
      EOF_Error <= eof_err_d;
      Overload  <= ovl_d;
      Frame_OK  <= ok_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    eof_err_d = 1'b0;
    ovl_d     = 1'b0;
    ok_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (Ext_Error) begin
          state_d = S_ERR_FLAG;
          cnt_d   = 4'd0;
        end else if (EOF_Flag) begin
          state_d = S_EOF;
          cnt_d   = 4'd0;
        end
      end
      S_EOF: begin
        // Ext_Error overrides any decision made by a coincident SP
        if (Ext_Error) begin
          state_d = S_ERR_FLAG;
          cnt_d   = 4'd0;
        end else if (SP) begin
          if (cnt_q == EOF_LAST) begin
            ok_d    = 1'b1;
            ovl_d   = ~RX;
            state_d = S_IFS;
            cnt_d   = 4'd0;
          end else if (!RX) begin
            eof_err_d = 1'b1;
            state_d   = S_ERR_FLAG;
            cnt_d     = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      S_ERR_FLAG: begin
        if (SP) begin
          if (cnt_q == FLAG_LAST) begin
            state_d = S_DELIM_WAIT;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      S_DELIM_WAIT: begin
        // first recessive bit after the flag is delimiter bit 1
        if (SP && RX) begin
          state_d = S_DELIM;
          cnt_d   = 4'd1;
        end
      end
      S_DELIM: begin
        if (SP) begin
          if (!RX) begin
            state_d = S_ERR_FLAG;
            cnt_d   = 4'd0;
          end else if (cnt_q == DELIM_LAST) begin
            state_d = S_IFS;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      S_IFS: begin
        if (Ext_Error) begin
          state_d = S_ERR_FLAG;
          cnt_d   = 4'd0;
        end else if (SP) begin
          if (!RX) begin
            ovl_d   = (cnt_q != IFS_LAST);
            state_d = S_IDLE;
            cnt_d   = 4'd0;
          end else if (cnt_q == IFS_LAST) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  assign State = state_q;
  assign Busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_eof_error_frame_ctrl.sv
// Directed bench for eof_error_frame_ctrl.
// Checks EOF outcomes, error frame timing, IFS overload and async reset.
module tb_eof_error_frame_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       SP = 1'b0, RX = 1'b1;
  logic       EOF_Flag = 1'b0, Ext_Error = 1'b0;
  logic       TX, EOF_Error, Overload, Frame_OK, Busy;
  logic [2:0] State;

  int vecs = 0;
  int errs = 0;

  eof_error_frame_ctrl dut (
    .clock(clock), .reset(reset), .SP(SP), .RX(RX),
    .EOF_Flag(EOF_Flag), .Ext_Error(Ext_Error),
    .TX(TX), .EOF_Error(EOF_Error), .Overload(Overload),
    .Frame_OK(Frame_OK), .Busy(Busy), .State(State)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock with the given inputs; returns #1 after the edge
  task automatic cyc(input logic sp, input logic rx,
                     input logic ef, input logic ee);
    SP = sp; RX = rx; EOF_Flag = ef; Ext_Error = ee;
    @(posedge clock);
    #1;
    SP = 1'b0; RX = 1'b1; EOF_Flag = 1'b0; Ext_Error = 1'b0;
  endtask

  task automatic ifs_clean(input string tag);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk({tag, "_ifs_st"}, 8'(State), (i == 2) ? 8'd0 : 8'd5);
      chk({tag, "_ifs_ovl"}, 8'(Overload), 8'd0);
    end
    chk({tag, "_ifs_tx"}, 8'(TX), 8'd1);
    chk({tag, "_ifs_busy"}, 8'(Busy), 8'd0);
  endtask

  task automatic clean_frame(input string tag);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk({tag, "_arm_st"}, 8'(State), 8'd1);
    chk({tag, "_arm_busy"}, 8'(Busy), 8'd1);
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk({tag, "_eof_ok"}, 8'(Frame_OK), (i == 6) ? 8'd1 : 8'd0);
      chk({tag, "_eof_err"}, 8'(EOF_Error), 8'd0);
      chk({tag, "_eof_tx"}, 8'(TX), 8'd1);
    end
    chk({tag, "_eof_st"}, 8'(State), 8'd5);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk({tag, "_ok_pulse"}, 8'(Frame_OK), 8'd0);
    ifs_clean(tag);
  endtask

  // six flag SPs with a gap cycle after each; TX must stay dominant
  task automatic flag6(input string tag);
    for (int i = 0; i < 6; i++) begin
      chk({tag, "_flag_tx"}, 8'(TX), 8'd0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk({tag, "_flag_st"}, 8'(State), (i == 5) ? 8'd3 : 8'd2);
      if (i < 5) begin
        chk({tag, "_flag_tx2"}, 8'(TX), 8'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0);
      end
    end
    chk({tag, "_flag_end_tx"}, 8'(TX), 8'd1);
  endtask

  task automatic delim8(input string tag);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk({tag, "_dl_st"}, 8'(State), (i == 7) ? 8'd5 : 8'd4);
      chk({tag, "_dl_tx"}, 8'(TX), 8'd1);
      chk({tag, "_dl_ok"}, 8'(Frame_OK), 8'd0);
    end
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    chk("rst_st", 8'(State), 8'd0);
    chk("rst_tx", 8'(TX), 8'd1);
    chk("rst_busy", 8'(Busy), 8'd0);
    chk("rst_pulses", {5'd0, EOF_Error, Overload, Frame_OK}, 8'd0);
    reset = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);

    // 1: clean frame
    clean_frame("t1");

    // 2: dominant EOF bit 4
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b1, 1'b0, 1'b0);
      chk("t2_eof_st", 8'(State), 8'd1);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t2_err", 8'(EOF_Error), 8'd1);
    chk("t2_err_st", 8'(State), 8'd2);
    chk("t2_ok", 8'(Frame_OK), 8'd0);
    flag6("t2");
    chk("t2_err_pulse", 8'(EOF_Error), 8'd0);
    delim8("t2");
    ifs_clean("t2");

    // 3: dominant last EOF bit, then dominant IFS bit 3 as SOF
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_ok", 8'(Frame_OK), 8'd1);
    chk("t3_ovl", 8'(Overload), 8'd1);
    chk("t3_err", 8'(EOF_Error), 8'd0);
    chk("t3_st", 8'(State), 8'd5);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t3_ifs2_st", 8'(State), 8'd5);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t3_sof_st", 8'(State), 8'd0);
    chk("t3_sof_ovl", 8'(Overload), 8'd0);

    // 4: dominant first EOF bit, flag stretched by other nodes
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t4_err", 8'(EOF_Error), 8'd1);
    chk("t4_st", 8'(State), 8'd2);
    flag6("t4");
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      chk("t4_dw_st", 8'(State), 8'd3);
      chk("t4_dw_tx", 8'(TX), 8'd1);
    end
    delim8("t4");
    ifs_clean("t4");

    // 5: EOF_Flag with Ext_Error, dominant delimiter bit 3, IFS overload
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    chk("t5_both_st", 8'(State), 8'd2);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("t5_ef_ign", 8'(State), 8'd2);
    flag6("t5a");
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t5_dl2_st", 8'(State), 8'd4);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5_dl3_st", 8'(State), 8'd2);
    chk("t5_dl3_err", 8'(EOF_Error), 8'd0);
    flag6("t5b");
    delim8("t5");
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t5_ovl", 8'(Overload), 8'd1);
    chk("t5_ovl_st", 8'(State), 8'd0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t5_ovl_pulse", 8'(Overload), 8'd0);

    // Ext_Error coincident with the deciding last EOF SP
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b1);
    chk("t5_ext_st", 8'(State), 8'd2);
    chk("t5_ext_pulses", {5'd0, EOF_Error, Overload, Frame_OK}, 8'd0);

    // 6: async reset after 3 flag SPs
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("t6_pre_tx", 8'(TX), 8'd0);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_tx", 8'(TX), 8'd1);
    chk("t6_rst_st", 8'(State), 8'd0);
    chk("t6_rst_busy", 8'(Busy), 8'd0);
    #2 reset = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("t6_idle_st", 8'(State), 8'd0);
    clean_frame("t6");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/eof_error_frame_ctrl.md
Name: eof_error_frame_ctrl

Overview:
Sequencer for the end-of-frame and error-signalling phase of the CAN receive path, clocked by the system clock.
- Arms on EOF_Flag and checks the EOF field bit by bit at each SP strobe.
- Classifies the outcome: frame OK, EOF error or overload.
- On an EOF error or an external error request, drives a complete error frame on TX (error flag, then error delimiter), then intermission, then returns to idle.

Parameters:
EOF_LEN, 7, recessive bits in EOF field (2..15)
FLAG_LEN, 6, dominant bits driven as error flag (1..15)
DELIM_LEN, 8, recessive bits in error delimiter (2..15)
IFS_LEN, 3, intermission bits (2..15)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
SP  in  1  sample-point strobe, one clock wide, once per bit time
RX  in  1  bus level at sample point (0 = dominant)
EOF_Flag  in  1  EOF field begins; next SP samples EOF bit 1
Ext_Error  in  1  error request from other checkers (stuff/CRC/form), one clock pulse
TX  out  1  bus drive (0 = dominant, 1 = recessive)
EOF_Error  out  1  one-clock pulse: dominant bit in EOF bits 1..EOF_LEN-1
Overload  out  1  one-clock pulse: overload condition detected
Frame_OK  out  1  one-clock pulse: EOF field accepted
Busy  out  1  high in every state except IDLE
State  out  3  current state encoding, for debug

Behaviour:
- Reset (reset=0): immediate and asynchronous, including mid-frame. Resulting values: State=IDLE, counter=0, TX=1, EOF_Error=0, Overload=0, Frame_OK=0, Busy=0.
- Outputs are registered. Pulses appear the clock after the SP edge that decides them.
- Bit counter is 4 bits, cleared on every state entry, and incremented only on SP.
- State encoding: IDLE=0, EOF=1, ERR_FLAG=2, DELIM_WAIT=3, DELIM=4, IFS=5.

Per-state rules:
- IDLE:
  - TX=1.
  - Ext_Error=1 -> ERR_FLAG. Ext_Error has priority over EOF_Flag in the same clock.
  - Otherwise EOF_Flag=1 -> EOF.
  - An SP coinciding with the arming clock is not counted.
- EOF (on each SP):
  - RX=0 with cnt < EOF_LEN-1 -> EOF_Error pulse, go to ERR_FLAG.
  - RX=0 with cnt = EOF_LEN-1 (last bit) -> Frame_OK pulse and Overload pulse, go to IFS. This is not an error.
  - RX=1 with cnt = EOF_LEN-1 -> Frame_OK pulse, go to IFS.
  - Otherwise cnt++.
- ERR_FLAG:
  - TX=0 from the clock after entry.
  - After the FLAG_LEN-th SP -> DELIM_WAIT, with TX=1 on the next clock.
  - RX is ignored in this state.
- DELIM_WAIT:
  - TX=1.
  - An SP with RX=1 -> DELIM, with cnt=1 (this bit counts as delimiter bit 1).
  - An SP with RX=0 stays in DELIM_WAIT; other nodes are still flagging.
  - No timeout.
- DELIM:
  - TX=1.
  - SP with RX=1: cnt++. When cnt reaches DELIM_LEN -> IFS.
  - SP with RX=0 -> ERR_FLAG (new error frame, no EOF_Error pulse).
- IFS:
  - TX=1.
  - SP with RX=0 at intermission bit 1..IFS_LEN-1 -> Overload pulse, go to IDLE.
  - SP with RX=0 at bit IFS_LEN -> IDLE, no pulse. The bit is treated as SOF.
  - After IFS_LEN recessive SPs -> IDLE.
- Ext_Error:
  - In IDLE, EOF and IFS -> ERR_FLAG on the next clock.
  - Ignored in ERR_FLAG, DELIM_WAIT and DELIM.
  - If an Ext_Error and a deciding SP fall in the same clock in EOF, Ext_Error wins and no EOF pulses are emitted.
- EOF_Flag is ignored outside IDLE.
- Busy = (State != IDLE).

Test Plan:
1. Clean frame: reset pulse, then EOF_Flag, then 7 SPs with RX=1 -> one Frame_OK pulse after the 7th SP. Then 3 recessive SPs -> State=IDLE, TX=1 throughout, no EOF_Error.
2. Dominant EOF bit 4: EOF_Flag, SPs with RX=1,1,1,0 -> EOF_Error pulse after the 4th SP. TX=0 for exactly 6 SPs. Then 8 recessive SPs in delimiter plus 3 in IFS -> IDLE, no Frame_OK.
3. Dominant last EOF bit: 6 recessive SPs then RX=0 on the 7th -> Frame_OK and Overload pulses, no EOF_Error, State=IFS.
4. Dominant first EOF bit: RX=0 on SP 1 -> EOF_Error pulse. Flag stretched by other nodes (RX=0 for 4 SPs in DELIM_WAIT) -> remains in DELIM_WAIT; first RX=1 counts as delimiter bit 1; 7 more recessive SPs -> IFS.
5. Simultaneous and illegal inputs:
   - EOF_Flag and Ext_Error in the same clock in IDLE -> ERR_FLAG.
   - RX=0 at delimiter bit 3 -> ERR_FLAG again, TX=0 for 6 SPs.
   - RX=0 at IFS bit 2 -> Overload pulse, IDLE.
6. Reset mid-error-flag (after 3 SPs) -> TX=1 and State=0 immediately, without a clock. After release, a clean sequence as in test 1 passes.
